// File: rtl/ef_pwm_deadtime.sv
// Dead-time insertion stage: turns one raw PWM channel into a non-overlapping
// high/low gate-drive pair, with latched fault shutdown and a swallowed-pulse counter.
module ef_pwm_deadtime #(
  parameter int unsigned DT_W = 8,
  parameter int unsigned SC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            pwm_in,
  input  logic [DT_W-1:0] dt_rise,
  input  logic [DT_W-1:0] dt_fall,
  input  logic            pol_h,
  input  logic            pol_l,
  input  logic            fault_in,
  input  logic            fault_clr,
  output logic            out_h,
  output logic            out_l,
  output logic            dt_active,
  output logic            fault_sts,
  output logic [SC_W-1:0] short_cnt,
  input  logic            short_clr
);

  typedef enum logic [2:0] {
    StOff,
    StLow,
    StDtRise,
    StHigh,
    StDtFall,
    StFault
  } state_e;

  state_e          state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic [SC_W-1:0] short_cnt_d;
  logic            swallow;
  logic            h_lvl, l_lvl, dt_lvl, fault_lvl;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    swallow = 1'b0;
    if (fault_in) begin
      state_d = StFault;
    end else if (!en && (state_q != StFault)) begin
      state_d = StOff;
    end else begin
      unique case (state_q)
        StOff: begin
          // Leaving OFF always goes through a full dead time before driving.
          if (pwm_in) begin
            state_d = StDtRise;
            cnt_d   = dt_rise;
          end else begin
            state_d = StDtFall;
            cnt_d   = dt_fall;
          end
        end
        StLow: begin
          if (pwm_in) begin
            state_d = StDtRise;
            cnt_d   = dt_rise;
          end
        end
        StDtRise: begin
          if (!pwm_in) begin
            state_d = StLow;
            swallow = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = StHigh;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        StHigh: begin
          if (!pwm_in) begin
            state_d = StDtFall;
            cnt_d   = dt_fall;
          end
        end
        StDtFall: begin
          if (pwm_in) begin
            state_d = StHigh;
            swallow = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = StLow;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        StFault: begin
          // fault_in is known low here; it is handled above.
          if (fault_clr) begin
            state_d = StOff;
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  always_comb begin
    short_cnt_d = short_cnt;
    if (short_clr) begin
      short_cnt_d = '0;
    end else if (swallow && (short_cnt != '1)) begin
      short_cnt_d = short_cnt + SC_W'(1);
    end
  end

  // Outputs follow the next state so they change on the same edge as the FSM.
  assign h_lvl     = (state_d == StHigh);
  assign l_lvl     = (state_d == StLow);
  assign dt_lvl    = (state_d == StDtRise) || (state_d == StDtFall);
  assign fault_lvl = (state_d == StFault);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StOff;
      cnt_q     <= '0;
      short_cnt <= '0;
      out_h     <= 1'b0;
      out_l     <= 1'b0;
      dt_active <= 1'b0;
      fault_sts <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      short_cnt <= short_cnt_d;
      out_h     <= h_lvl ^ pol_h;
      out_l     <= l_lvl ^ pol_l;
      dt_active <= dt_lvl;
      fault_sts <= fault_lvl;
    end
  end

endmodule

// File: tb/tb_ef_pwm_deadtime.sv
// Self-checking bench for ef_pwm_deadtime: cycle model feeds a scoreboard queue,
// plus directed checks of dead-time gaps, swallowing, fault and polarity behaviour.
module tb_ef_pwm_deadtime;

  logic       clk;
  logic       rst, en, pwm_in, pol_h, pol_l, fault_in, fault_clr, short_clr;
  logic [7:0] dt_rise, dt_fall;
  logic       out_h, out_l, dt_active, fault_sts;
  logic [15:0] short_cnt;
  logic       out_h2, out_l2, dt_active2, fault_sts2;
  logic [1:0] short_cnt2;

  ef_pwm_deadtime #(.DT_W(8), .SC_W(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in), .dt_rise(dt_rise), .dt_fall(dt_fall),
    .pol_h(pol_h), .pol_l(pol_l), .fault_in(fault_in), .fault_clr(fault_clr),
    .out_h(out_h), .out_l(out_l), .dt_active(dt_active), .fault_sts(fault_sts),
    .short_cnt(short_cnt), .short_clr(short_clr)
  );

  ef_pwm_deadtime #(.DT_W(8), .SC_W(2)) u_dut_sc2 (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in), .dt_rise(dt_rise), .dt_fall(dt_fall),
    .pol_h(pol_h), .pol_l(pol_l), .fault_in(fault_in), .fault_clr(fault_clr),
    .out_h(out_h2), .out_l(out_l2), .dt_active(dt_active2), .fault_sts(fault_sts2),
    .short_cnt(short_cnt2), .short_clr(short_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        h;
    logic        l;
    logic        dt;
    logic        f;
    logic [15:0] sc;
    logic [1:0]  sc2;
  } exp_t;

  localparam int MOff = 0, MLow = 1, MDtr = 2, MHigh = 3, MDtf = 4, MFault = 5;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_st = MOff, m_cnt = 0, m_sc = 0, m_sc2 = 0;
  int   cyc = 0;
  bit   gap_en = 0;
  int   gap_lh = 0, gap_hl = 0;
  int   l_fall_cyc = 0, h_fall_cyc = 0;
  bit   l_fall_v = 0, h_fall_v = 0;
  logic prev_lh = 0, prev_ll = 0;
  bit   h_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference behaviour, one clock edge per call, using the inputs as currently driven.
  task automatic model_step();
    exp_t e;
    bit   sw;
    int   nst;
    e = '0;
    if (rst) begin
      m_st = MOff; m_cnt = 0; m_sc = 0; m_sc2 = 0;
    end else begin
      sw  = 0;
      nst = m_st;
      if (fault_in) nst = MFault;
      else if (!en && m_st != MFault) nst = MOff;
      else begin
        case (m_st)
          MOff: begin
            nst   = pwm_in ? MDtr : MDtf;
            m_cnt = pwm_in ? int'(dt_rise) : int'(dt_fall);
          end
          MLow:  if (pwm_in) begin nst = MDtr; m_cnt = int'(dt_rise); end
          MHigh: if (!pwm_in) begin nst = MDtf; m_cnt = int'(dt_fall); end
          MDtr: begin
            if (!pwm_in) begin nst = MLow; sw = 1; end
            else if (m_cnt == 0) nst = MHigh;
            else m_cnt--;
          end
          MDtf: begin
            if (pwm_in) begin nst = MHigh; sw = 1; end
            else if (m_cnt == 0) nst = MLow;
            else m_cnt--;
          end
          default: if (fault_clr) nst = MOff;
        endcase
      end
      if (short_clr) begin
        m_sc = 0; m_sc2 = 0;
      end else if (sw) begin
        if (m_sc < 65535) m_sc++;
        if (m_sc2 < 3) m_sc2++;
      end
      m_st  = nst;
      e.h   = (nst == MHigh) ^ pol_h;
      e.l   = (nst == MLow) ^ pol_l;
      e.dt  = (nst == MDtr) || (nst == MDtf);
      e.f   = (nst == MFault);
      e.sc  = 16'(m_sc);
      e.sc2 = 2'(m_sc2);
    end
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    logic lh, ll;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    e = sb.pop_front();
    check_eq("out_h", out_h, e.h);
    check_eq("out_l", out_l, e.l);
    check_eq("dt_active", dt_active, e.dt);
    check_eq("fault_sts", fault_sts, e.f);
    check_eq("short_cnt", short_cnt, e.sc);
    check_eq("sc2_short_cnt", short_cnt2, e.sc2);
    check_eq("sc2_outs", {out_h2, out_l2, dt_active2, fault_sts2}, {e.h, e.l, e.dt, e.f});
    if (rst) begin
      prev_lh = 0; prev_ll = 0;
    end else begin
      lh = out_h ^ pol_h;
      ll = out_l ^ pol_l;
      check_eq("overlap", lh & ll, 0);
      if (gap_en) begin
        if (prev_ll && !ll) begin l_fall_cyc = cyc; l_fall_v = 1; end
        if (prev_lh && !lh) begin h_fall_cyc = cyc; h_fall_v = 1; end
        if (!prev_lh && lh && l_fall_v) begin
          check_eq("gap_l_to_h", cyc - l_fall_cyc, gap_lh);
          l_fall_v = 0;
        end
        if (!prev_ll && ll && h_fall_v) begin
          check_eq("gap_h_to_l", cyc - h_fall_cyc, gap_hl);
          h_fall_v = 0;
        end
      end
      if (lh) h_seen = 1;
      prev_lh = lh;
      prev_ll = ll;
    end
  endtask

  task automatic set_gap(input bit on, input int lh_gap, input int hl_gap);
    gap_en = on; gap_lh = lh_gap; gap_hl = hl_gap;
    l_fall_v = 0; h_fall_v = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1; en = 0; pwm_in = 0; pol_h = 0; pol_l = 0;
    fault_in = 0; fault_clr = 0; short_clr = 0; dt_rise = 0; dt_fall = 0;
    ticks(2);
    check_eq("rst_outs", {out_h, out_l, dt_active, fault_sts}, 4'b0000);
    check_eq("rst_cnt", short_cnt, 0);
    rst = 0;

    // Basic pair: dt_rise=3, dt_fall=5, period 40 at 50% duty.
    en = 1; dt_rise = 3; dt_fall = 5;
    set_gap(1, 4, 6);
    ticks(20);
    for (int p = 0; p < 3; p++) begin
      pwm_in = 1; ticks(20);
      pwm_in = 0; ticks(20);
    end
    check_eq("basic_no_swallow", short_cnt, 0);
    set_gap(0, 0, 0);

    // Swallowed pulse: 3-cycle high while dt_rise=6.
    dt_rise = 6; h_seen = 0;
    short_clr = 1; tick(); short_clr = 0;
    for (int p = 0; p < 5; p++) begin
      pwm_in = 1; ticks(3);
      pwm_in = 0; ticks(6);
      if (p == 0) begin
        check_eq("swallow_cnt1", short_cnt, 1);
        check_eq("swallow_low_back", out_l, 1);
      end
    end
    check_eq("swallow_h_never", h_seen, 0);
    check_eq("swallow_cnt5", short_cnt, 5);
    check_eq("sc2_saturate", short_cnt2, 3);
    pwm_in = 1; tick();
    pwm_in = 0; short_clr = 1; tick(); short_clr = 0;
    check_eq("clr_beats_inc", short_cnt, 0);
    check_eq("sc2_clr_beats_inc", short_cnt2, 0);
    ticks(8);

    // Zero dead time: one both-off cycle per transition, toggling is always swallowed.
    dt_rise = 0; dt_fall = 0;
    set_gap(1, 1, 1);
    for (int p = 0; p < 2; p++) begin
      pwm_in = 1; ticks(10);
      pwm_in = 0; ticks(10);
    end
    short_clr = 1; tick(); short_clr = 0;
    for (int p = 0; p < 8; p++) begin
      pwm_in = 1; tick();
      pwm_in = 0; tick();
    end
    check_eq("zero_dt_toggle_cnt", short_cnt, 8);
    set_gap(0, 0, 0);
    ticks(4);

    // Fault from HIGH, clear held off while fault_in is high.
    dt_rise = 3; pwm_in = 1; ticks(6);
    check_eq("pre_fault_high", out_h, 1);
    fault_in = 1; tick();
    check_eq("fault_h_off", {out_h, out_l, fault_sts}, 3'b001);
    fault_clr = 1; tick();
    check_eq("fault_clr_ignored", fault_sts, 1);
    fault_clr = 0; fault_in = 0; tick();
    check_eq("fault_latched", fault_sts, 1);
    fault_clr = 1; tick(); fault_clr = 0;
    check_eq("fault_to_off", {out_h, out_l, dt_active, fault_sts}, 4'b0000);
    tick();
    check_eq("post_fault_dt", dt_active, 1);
    ticks(3);
    check_eq("post_fault_still_off", {out_h, dt_active}, 2'b01);
    tick();
    check_eq("post_fault_drive", {out_h, dt_active}, 2'b10);

    // Inverted polarity, enable drop mid dead time, reset while HIGH.
    pol_h = 1; pol_l = 1; en = 0; ticks(2);
    check_eq("pol_idle_off", {out_h, out_l}, 2'b11);
    en = 1; pwm_in = 0; dt_fall = 2; ticks(4);
    check_eq("pol_low_on", {out_h, out_l}, 2'b10);
    pwm_in = 1; dt_rise = 5; ticks(2);
    check_eq("pol_in_dtr", dt_active, 1);
    en = 0; tick();
    check_eq("en_drop_off", {out_h, out_l, dt_active}, 3'b110);
    en = 1; ticks(7);
    check_eq("pol_high_on", {out_h, out_l}, 2'b01);
    rst = 1; tick(); rst = 0;
    check_eq("rst_in_high", {out_h, out_l, dt_active}, 3'b000);
    pol_h = 0; pol_l = 0;

    // Random mixed traffic against the model.
    for (int i = 0; i < 300; i++) begin
      en        = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0) pwm_in = ~pwm_in;
      dt_rise   = 8'($urandom_range(0, 3));
      dt_fall   = 8'($urandom_range(0, 3));
      fault_in  = ($urandom_range(0, 39) == 0);
      fault_clr = ($urandom_range(0, 7) == 0);
      short_clr = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ef_pwm_deadtime.md
# ef_pwm_deadtime

Dead-time and complementary-output stage placed directly downstream of the 32-bit PWM generator. It takes one raw PWM channel (pwmA or pwmB) and produces a non-overlapping high-side/low-side gate-drive pair with programmable rising- and falling-edge dead times. It also provides a latched fault shutdown and a saturating counter of input pulses swallowed by dead time. One instance is used per PWM channel.

## Interface
- DT_W, 8, width of dead-time count inputs
- SC_W, 16, width of swallowed-pulse counter

- clk  in  1  block clock, same domain as the PWM generator
- rst  in  1  synchronous, active-high reset
- en  in  1  stage enable; 0 forces both outputs inactive
- pwm_in  in  1  raw PWM from generator, same clock domain, no synchronizer
- dt_rise  in  DT_W  low-off to high-on gap, in cycles minus 1
- dt_fall  in  DT_W  high-off to low-on gap, in cycles minus 1
- pol_h  in  1  1 inverts out_h
- pol_l  in  1  1 inverts out_l
- fault_in  in  1  active-high fault, level-sensitive
- fault_clr  in  1  single-cycle pulse that releases the fault latch
- out_h  out  1  high-side drive, registered
- out_l  out  1  low-side drive, registered
- dt_active  out  1  1 while in a dead-time state
- fault_sts  out  1  1 while in FAULT
- short_cnt  out  SC_W  swallowed-pulse count, saturating
- short_clr  in  1  pulse that clears short_cnt

## Operation
- FSM states: OFF, LOW, DT_RISE, HIGH, DT_FALL, FAULT. Reset state is OFF.
- Logical drive levels:
  - h_lvl = 1 only in HIGH.
  - l_lvl = 1 only in LOW.
  - Both are 0 in all other states.
- Registered outputs: out_h <= h_lvl ^ pol_h, out_l <= l_lvl ^ pol_l.
- Transition priority, highest first:
  1. fault_in=1 -> FAULT.
  2. en=0 -> OFF. This rule is skipped when the current state is FAULT.
  3. State-specific rules below.
- State-specific rules:
  - OFF:
    - pwm_in=1 -> DT_RISE, cnt<=dt_rise.
    - pwm_in=0 -> DT_FALL, cnt<=dt_fall.
  - LOW: pwm_in=1 -> DT_RISE, cnt<=dt_rise.
  - DT_RISE:
    - pwm_in=0 -> LOW, and short_cnt increments. This is a swallowed pulse.
    - Otherwise, cnt==0 -> HIGH; if cnt is nonzero, cnt decrements.
  - HIGH: pwm_in=0 -> DT_FALL, cnt<=dt_fall.
  - DT_FALL:
    - pwm_in=1 -> HIGH, and short_cnt increments.
    - Otherwise, cnt==0 -> LOW; if cnt is nonzero, cnt decrements.
  - FAULT: fault_clr=1 and fault_in=0 -> OFF. Otherwise stay in FAULT.
- Simultaneous fault_in and fault_clr: the fault wins.
- dt_rise and dt_fall are sampled only when cnt is loaded. Changing them during a dead time does not affect the dead time in progress.
- short_cnt:
  - Saturates at all-ones.
  - short_clr takes priority over an increment in the same cycle; the result is 0.
- dt_active = registered (state is DT_RISE or DT_FALL).
- fault_sts = registered (state is FAULT).

## Timing
- Reset (rst=1 at an edge) forces these values at that edge, regardless of the pol inputs:
  - state=OFF, cnt=0, short_cnt=0.
  - out_h=0, out_l=0, dt_active=0, fault_sts=0.
- Edge numbering: k = first clock edge at which pwm_in=1 is sampled while the state is LOW.
  - At edge k: out_l deasserts, dt_active=1.
  - At edge k+dt_rise+1: out_h asserts, dt_active=0.
  - Both-off interval is exactly dt_rise+1 cycles; the minimum is 1 cycle when dt=0.
- Falling edge of pwm_in behaves the same way, using dt_fall.
- Propagation latency from pwm_in to the active output is dt+2 edges, counted from the pwm_in change.
- out_h and out_l (logical levels) are never 1 in the same cycle. This holds across every state, en and fault combination.
- fault_in sampled high at edge m: both outputs are at the inactive level after edge m, with no dead time. fault_sts=1 after edge m.
- Leaving FAULT always passes through OFF and then a full dead time before any output drives.
- rst asserted mid-dead-time: the dead time is aborted and the block returns to OFF. No output pulse is produced.

## Test plan
- Basic pair: en=1, dt_rise=3, dt_fall=5, pwm_in period 40 with 50% duty.
  - Required: each out_l fall is followed by out_h rise exactly 4 cycles later.
  - Required: each out_h fall is followed by out_l rise exactly 6 cycles later.
  - Required: no overlap ever.
- Swallowed pulse: dt_rise=6, pwm_in high for 3 cycles while in LOW.
  - Required: out_h never asserts, out_l returns to 1, short_cnt=1.
  - Repeat with SC_W=2 for 5 pulses. Required: short_cnt saturates at 3.
  - short_clr in the same cycle as an increment. Required: short_cnt=0.
- Zero dead time: dt_rise=dt_fall=0.
  - Required: exactly 1 both-off cycle at every transition.
  - Required: pwm_in toggling every cycle is swallowed and counted every time.
- Fault: assert fault_in while in HIGH.
  - Required: out_h=0 and fault_sts=1 next cycle.
  - fault_clr while fault_in=1. Required: stays in FAULT.
  - fault_clr after fault_in drops. Required: OFF, then dead time, then normal drive.
- Polarity/enable: pol_h=pol_l=1.
  - Required: outputs idle at 1 in OFF.
  - Drop en during DT_RISE. Required: OFF next edge, both outputs at inactive levels.
  - rst asserted in HIGH. Required: out_h=out_l=0 next edge.
